// File: rtl/pll_rst_sequencer.sv
// Reset sequencer for a board PLL: pulses the PLL reset, waits for a stable
// synchronised lock, then releases CHANNELS reset outputs in staggered order.
module pll_rst_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int HOLD_CYCLES    = 16,
   parameter int CHANNELS       = 1,
   parameter int STAGGER        = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_locked,
   output logic                o_pll_rst,
   output logic [CHANNELS-1:0] o_rst,
   output logic                o_ready,
   output logic [7:0]          o_retries,
   output logic [7:0]          o_lost
);

   localparam int LAST_OFFSET = (CHANNELS - 1) * STAGGER;
   localparam int MAX_A       = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
   localparam int MAX_B       = (HOLD_CYCLES > LAST_OFFSET + 1) ? HOLD_CYCLES : LAST_OFFSET + 1;
   localparam int MAX_COUNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W       = $clog2(MAX_COUNT + 1);

   typedef enum logic [2:0] {
      ST_PLLRST,
      ST_WAIT,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                  locked_s;
   logic                  timeout_hit;
   logic                  loss_hit;
   logic                  pll_rst_q;
   logic                  pll_rst_d;
   logic [CHANNELS-1:0]   rst_q;
   logic [CHANNELS-1:0]   rst_d;
   logic                  ready_q;
   logic                  ready_d;
   logic [7:0]            retries_q;
   logic [7:0]            lost_q;

   // Lock is asynchronous to i_clk; only the last synchroniser stage is used.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_PLLRST;
         cnt_q     <= '0;
         pll_rst_q <= 1'b1;
         rst_q     <= '1;
         ready_q   <= 1'b0;
         retries_q <= 8'd0;
         lost_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pll_rst_q <= pll_rst_d;
         rst_q     <= rst_d;
         ready_q   <= ready_d;
         if (timeout_hit && (retries_q != 8'hFF)) begin
            retries_q <= retries_q + 8'd1;
         end
         if (loss_hit && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
         end
      end
   end

   // Lock is checked before the timeout so a simultaneous arrival wins, and
   // loss is checked before the last release so o_ready never rises on it.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      loss_hit    = 1'b0;
      case (state_q)
         ST_PLLRST: begin
            if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (locked_s) begin
               state_d = ST_HOLD;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d     = ST_PLLRST;
               timeout_hit = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!locked_s) begin
               state_d = ST_WAIT;
            end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = (LAST_OFFSET == 0) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!locked_s) begin
               state_d  = ST_WAIT;
               loss_hit = 1'b1;
            end else if (cnt_q == CNT_W'(LAST_OFFSET - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d  = ST_WAIT;
               loss_hit = 1'b1;
            end
         end
         default: begin
            state_d = ST_PLLRST;
         end
      endcase
      if ((state_d != state_q) || (state_q == ST_RUN)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state and counter so they are
   // registered yet line up with the state they belong to.
   always_comb begin
      rst_d     = '1;
      ready_d   = (state_d == ST_RUN);
      pll_rst_d = (state_d == ST_PLLRST);
      case (state_d)
         ST_RUN: begin
            rst_d = '0;
         end
         ST_RELEASE: begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (cnt_d >= CNT_W'(k * STAGGER)) begin
                  rst_d[k] = 1'b0;
               end
            end
         end
         default: begin
            rst_d = '1;
         end
      endcase
   end

   assign o_pll_rst = pll_rst_q;
   assign o_rst     = rst_q;
   assign o_ready   = ready_q;
   assign o_retries = retries_q;
   assign o_lost    = lost_q;

endmodule

// File: doc/pll_rst_sequencer.md
# pll_rst_sequencer

Parametrised reset sequencer that sits beside the board PLL in every clock-generation wrapper. It drives the PLL reset and watches the asynchronous PLL lock. It holds reset until lock has been stable for a programmable time, then releases up to CHANNELS reset outputs in a staggered order. It re-asserts all resets on loss of lock and retries the PLL when lock never arrives. It runs on the free-running PLL input clock, so it keeps working while the PLL is unlocked.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser flops on i_locked (≥2).
- PLL_RST_CYCLES, 8: cycles o_pll_rst is held high per PLL reset pulse (≥1).
- LOCK_TIMEOUT, 65536: cycles waited for lock before re-pulsing PLL reset (≥2).
- HOLD_CYCLES, 16: consecutive locked cycles required before the first release (≥1).
- CHANNELS, 1: number of reset outputs (1..16).
- STAGGER, 4: cycles between successive channel releases (≥0; 0 = release all together).

Ports:
- i_clk  in  1  free-running reference clock (PLL input clock).
- i_rst  in  1  synchronous, active-high reset.
- i_locked  in  1  PLL LOCKED, asynchronous.
- o_pll_rst  out  1  PLL RST.
- o_rst  out  CHANNELS  per-domain active-high reset, i_clk-registered.
- o_ready  out  1  high when all channels are released.
- o_retries  out  8  saturating count of lock timeouts.
- o_lost  out  8  saturating count of lock losses after release.

## Operation
- i_locked passes through SYNC_STAGES flops to give locked_s. Only locked_s is used.
- States: PLLRST, WAIT, HOLD, RELEASE, RUN. A single counter is shared between states and cleared on every state change.
- PLLRST: o_pll_rst=1. After PLL_RST_CYCLES cycles → WAIT.
- WAIT: o_pll_rst=0.
  - locked_s=1 → HOLD.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0 → PLLRST, and o_retries increments (saturates at 255).
- HOLD:
  - locked_s=0 → WAIT. The timeout counter restarts and no PLL reset is issued.
  - HOLD_CYCLES consecutive cycles with locked_s=1 → RELEASE.
- RELEASE: o_rst[k] deasserts at release offset k·STAGGER, where offset 0 is the first RELEASE cycle. When channel CHANNELS-1 deasserts, the state moves to RUN and o_ready rises in the same cycle.
- RUN: all o_rst=0 and o_ready=1.
- Loss of lock: locked_s=0 in RELEASE or RUN takes effect on the next edge.
  - All o_rst=1 and o_ready=0.
  - o_lost increments (saturates at 255).
  - State → WAIT.
  - PLL reset is not pulsed, because the PLL re-locks by itself.
  - A channel released earlier does not stay released.
- Once deasserted, o_rst bits never reassert except through loss of lock or i_rst. The stagger order is fixed: low index first.

## Timing
- Reset values while i_rst=1 and on the first cycle after it:
  - state=PLLRST, counter=0.
  - o_pll_rst=1, o_rst=all ones, o_ready=0.
  - o_retries=0, o_lost=0.
  - Synchroniser flops are 0.
- i_rst mid-operation forces the reset values on the next edge regardless of state, including RUN.
- After i_rst falls, o_pll_rst stays high for exactly PLL_RST_CYCLES cycles.
- Lock latency: i_locked sampled high at edge E while in WAIT (or in the last PLLRST cycle) → o_rst[0] falls after edge E+SYNC_STAGES+HOLD_CYCLES. This assumes i_locked stays high throughout.
- o_rst[k] falls k·STAGGER cycles after o_rst[0]. o_ready rises with o_rst[CHANNELS-1].
- Loss latency: i_locked sampled low at edge E → all o_rst high after edge E+SYNC_STAGES.
- Simultaneous events in the same cycle:
  - Timeout versus lock arrival: lock wins, so the state goes to HOLD with no retry.
  - Loss versus the last channel release: loss wins, so o_ready stays 0.
- A lock glitch shorter than HOLD_CYCLES during HOLD restarts the sequence and is not counted in o_lost.
- o_retries and o_lost are held at 255 on saturation.

## Test plan
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, HOLD_CYCLES=8, CHANNELS=3, STAGGER=2.

1. Reset then clean lock: release i_rst; o_pll_rst is high for 4 cycles. Raise i_locked 3 cycles later. o_rst[0] falls 10 edges after i_locked is first sampled high, o_rst[1] 2 cycles later, and o_rst[2] together with o_ready 4 cycles later. o_retries=0.
2. No lock: hold i_locked=0. o_pll_rst pulses 4 cycles high every 36 cycles, and o_retries counts 1, 2, 3… Run to saturation: 255 is held.
3. Lock glitch in HOLD: i_locked high 5 cycles, low 1, then high. No release occurs until 10 edges after the second rise. o_lost=0, no PLL pulse.
4. Loss in RUN: in RUN, drop i_locked. All o_rst read 3'b111 and o_ready=0 after 2 edges, and o_lost=1. Re-raise i_locked: the full 10/12/14 release follows with no o_pll_rst pulse.
5. Loss during stagger: drop i_locked so locked_s falls in the cycle after o_rst[0] is released. All o_rst are high the next cycle and o_rst[0] does not stay low.
6. i_rst in RUN: assert i_rst for 1 cycle. The next cycle shows o_rst=3'b111, o_pll_rst=1, and both counters at 0. The full sequence then repeats.
